module_disp_mux: RTL and testbench
==================================

MODULE_DISP_MUX -- requirements
Module: module_disp_mux

Interface
REQ-001 SHALL have parameter FREQ_HZ, default 27_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter REFRESH_HZ, default 1_000: per-digit slot rate in Hz; DIV = FREQ_HZ/REFRESH_HZ clock cycles per slot, DIV >= 16.
REQ-003 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-004 SHALL have parameter INVERT_AN, default 1: 1 = anodes active-low at the pins.
REQ-005 SHALL have parameter INVERT_SEG, default 1: 1 = segments and dp active-low at the pins.
REQ-006 SHALL have port clk, input, 1 bit: single system clock, all state on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port data_i, input, 4*N_DIGITS bits: hex nibbles, nibble k drives digit k, digit N_DIGITS-1 most significant.
REQ-009 SHALL have port dp_i, input, N_DIGITS bits: decimal point per digit.
REQ-010 SHALL have port load_i, input, 1 bit: strobe that captures data_i/dp_i.
REQ-011 SHALL have port bright_i, input, 4 bits: brightness level 0..15.
REQ-012 SHALL have port an_o, output, N_DIGITS bits: one-hot digit anodes after INVERT_AN.
REQ-013 SHALL have port seg_o, output, 7 bits: segments {g,f,e,d,c,b,a} after INVERT_SEG.
REQ-014 SHALL have port dp_o, output, 1 bit: decimal point segment after INVERT_SEG.

Function
REQ-015 SHALL run slot counter 0..DIV-1, wrapping to 0; on each wrap, digit index advances by 1 and wraps from N_DIGITS-1 to 0.
REQ-016 SHALL define a frame boundary as the cycle the slot counter wraps while the index is N_DIGITS-1.
REQ-017 SHALL capture data_i/dp_i into a shadow register on any cycle with load_i=1.
REQ-018 SHALL copy the shadow register to the display register only at a frame boundary, so a frame never mixes old and new data.
REQ-019 SHALL route data_i/dp_i directly to the display register when load_i=1 coincides with a frame boundary, and also store them in the shadow register.
REQ-020 SHALL sample bright_i at slot counter 0 and hold the value for the whole slot.
REQ-021 SHALL drive the selected anode active while slot counter < ((bright+1)*DIV)>>4; otherwise all anodes inactive. bright=15 gives 100 % duty.
REQ-022 SHALL decode nibbles (gfedcba, active-high before inversion): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-023 SHALL register an_o/seg_o/dp_o with one cycle latency from the counter/index state; segments and dp SHALL be off whenever all anodes are inactive.

Reset
REQ-024 SHALL, while reset=1, asynchronously clear the slot counter, index, shadow register, display register and sampled brightness to 0.
REQ-025 SHALL hold all anodes inactive, all segments off and dp off (pin levels per INVERT_*) while reset=1; reset asserted mid-frame SHALL take effect without waiting for a clock edge.
REQ-026 SHALL make digit 0 the first digit driven after reset release, on the second rising edge after release.

Configuration
REQ-027 SHALL compile leading-zero blanking only when macro LEADING_ZERO_BLANK_EN is defined: a digit k>0 whose nibble and every higher nibble are 0 and whose dp bit is 0 has its anode held inactive during its slot; digit 0 is never blanked.
REQ-028 SHALL, without LEADING_ZERO_BLANK_EN, display every digit unconditionally.

Verification (FREQ_HZ=16, REFRESH_HZ=1 -> DIV=16, N_DIGITS=4, INVERT_*=0)
REQ-029 SHALL cover rotation: bright=15, reset release -> an_o 0001,0010,0100,1000 for 16 cycles each, repeating; wrap back to 0001 after 64 cycles.
REQ-030 SHALL cover decode and frame-sync load: load data_i=16'h12AF mid-frame -> old value persists to frame end; next frame digit 0 seg_o=1110001, digit 3 seg_o=0000110.
REQ-031 SHALL cover brightness: bright_i=3 -> anode active 4 of 16 cycles per slot; bright_i=0 -> 1 of 16; a change mid-slot applies only from the next slot.
REQ-032 SHALL cover reset mid-operation: assert reset at cycle 37 -> outputs inactive in the same cycle without a clock edge; after release the display register is 0 and digit 0 shows 0111111.
REQ-033 SHALL cover blanking with LEADING_ZERO_BLANK_EN: data 16'h0050, dp_i=0 -> digits 3 and 2 anodes never active, digit 1 shows 1101101; with dp_i=4'b1000, digit 3 shows 0111111 and dp_o=1.
REQ-034 SHALL cover load coincident with a frame boundary: load 16'h8888 on the boundary cycle -> the very next frame shows 1111111 on all digits.

Source files
------------

// File: rtl/module_disp_mux.sv
// Multiplexed hex 7-segment driver: slot/digit scan, frame-synchronous data load, PWM brightness.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module module_disp_mux #(
    parameter int FREQ_HZ    = 27_000_000,
    parameter int REFRESH_HZ = 1_000,
    parameter int N_DIGITS   = 4,
    parameter int INVERT_AN  = 1,
    parameter int INVERT_SEG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  load_i,
    input  logic [3:0]            bright_i,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o
);
    localparam int DIV = FREQ_HZ / REFRESH_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int IW  = $clog2(N_DIGITS);
    localparam logic INV_AN  = (INVERT_AN != 0);
    localparam logic INV_SEG = (INVERT_SEG != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  started;
    logic [4*N_DIGITS-1:0] shadow_data, disp_data;
    logic [N_DIGITS-1:0]   shadow_dp, disp_dp;
    logic [3:0]            bright_q;

    logic slot_end, frame_end;
    assign slot_end  = (cnt == CW'(DIV - 1));
    assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));

    // started delays the scan by one edge so digit 0 appears on the second edge after release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            started     <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            bright_q    <= '0;
        end else begin
            if (load_i) begin
                shadow_data <= data_i;
                shadow_dp   <= dp_i;
            end
            if (!started) begin
                started <= 1'b1;
            end else begin
                cnt <= slot_end ? '0 : cnt + 1'b1;
                if (slot_end)
                    idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
                if (cnt == '0)
                    bright_q <= bright_i;
                if (frame_end) begin
                    disp_data <= load_i ? data_i : shadow_data;
                    disp_dp   <= load_i ? dp_i   : shadow_dp;
                end
            end
        end
    end

    logic [3:0]          bright_cur;
    int unsigned         thr;
    logic [3:0]          nib;
    logic                dp_cur;
    logic                blank;
    logic                lit;
    logic [6:0]          seg_raw;
    logic [N_DIGITS-1:0] sel;

    // slot 0 uses bright_i directly so the value sampled at count 0 governs the whole slot
    always_comb begin
        bright_cur = (cnt == '0) ? bright_i : bright_q;
        thr        = ((32'(bright_cur) + 32'd1) * 32'(DIV)) >> 4;
        nib        = '0;
        dp_cur     = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib    = disp_data[4*k +: 4];
                dp_cur = disp_dp[k];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        zero_run = 1'b1;
        blank    = 1'b0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (disp_data[4*k +: 4] == 4'h0);
            if (idx == IW'(k) && zero_run && !disp_dp[k])
                blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        lit = started && !blank && (32'(cnt) < thr);
        sel = N_DIGITS'(1) << idx;
        case (nib)
            4'h0: seg_raw = 7'b0111111;
            4'h1: seg_raw = 7'b0000110;
            4'h2: seg_raw = 7'b1011011;
            4'h3: seg_raw = 7'b1001111;
            4'h4: seg_raw = 7'b1100110;
            4'h5: seg_raw = 7'b1101101;
            4'h6: seg_raw = 7'b1111101;
            4'h7: seg_raw = 7'b0000111;
            4'h8: seg_raw = 7'b1111111;
            4'h9: seg_raw = 7'b1101111;
            4'hA: seg_raw = 7'b1110111;
            4'hB: seg_raw = 7'b1111100;
            4'hC: seg_raw = 7'b0111001;
            4'hD: seg_raw = 7'b1011110;
            4'hE: seg_raw = 7'b1111001;
            default: seg_raw = 7'b1110001;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_o  <= {N_DIGITS{INV_AN}};
            seg_o <= {7{INV_SEG}};
            dp_o  <= INV_SEG;
        end else begin
            an_o  <= (lit ? sel : '0) ^ {N_DIGITS{INV_AN}};
            seg_o <= (lit ? seg_raw : 7'b0) ^ {7{INV_SEG}};
            dp_o  <= (lit && dp_cur) ^ INV_SEG;
        end
    end
endmodule

// File: tb/tb_module_disp_mux.sv
// Scoreboard bench for module_disp_mux at DIV=16, 4 digits, non-inverted pins.
// Expected pin values are queued with a cycle stamp; a negedge monitor pops and compares.
module tb_module_disp_mux;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic [3:0]  bright_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    module_disp_mux #(.FREQ_HZ(16), .REFRESH_HZ(1), .N_DIGITS(4), .INVERT_AN(0), .INVERT_SEG(0)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .dp_i(dp_i), .load_i(load_i),
        .bright_i(bright_i), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    localparam logic [6:0] SEG0 = 7'b0111111;
    localparam logic [6:0] SEG1 = 7'b0000110;
    localparam logic [6:0] SEG2 = 7'b1011011;
    localparam logic [6:0] SEG5 = 7'b1101101;
    localparam logic [6:0] SEG8 = 7'b1111111;
    localparam logic [6:0] SEGA = 7'b1110111;
    localparam logic [6:0] SEGF = 7'b1110001;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if ({an_o, seg_o, dp_o} !== {mon_e.an, mon_e.seg, mon_e.dp}) begin
                bad++;
                $display("FAIL pins cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         mon_e.cyc, an_o, seg_o, dp_o, mon_e.an, mon_e.seg, mon_e.dp);
            end
        end
    end

    task automatic wait_cyc(input int x);
        while (cyc < x) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_off(input int at);
        sb.push_back('{cyc: at, an: 4'b0, seg: 7'b0, dp: 1'b0});
    endtask

    task automatic push_slot(input int base, input int digit, input logic [6:0] seg,
                             input logic dp, input int on, input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.cyc = base + c;
            e.an  = (c < on) ? 4'(1 << digit) : 4'b0;
            e.seg = (c < on) ? seg : 7'b0;
            e.dp  = (c < on) ? dp : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_load(input int at, input logic [15:0] d, input logic [3:0] p);
        wait_cyc(at);
        data_i = d;
        dp_i   = p;
        load_i = 1'b1;
        @(posedge clk);
        #2;
        load_i = 1'b0;
    endtask

    initial begin
        int r;
        logic [6:0] seg12af[4];
        logic [6:0] sg;
        int on;
        logic dpv;

        seg12af[0] = SEGF; seg12af[1] = SEGA; seg12af[2] = SEG2; seg12af[3] = SEG1;
        reset = 1'b1; data_i = '0; dp_i = '0; load_i = 1'b0; bright_i = 4'd15;

        // run 1: rotation, frame-synced load, brightness, boundary load
        repeat (3) @(posedge clk);
        #2;
        push_off(cyc);
        @(posedge clk);
        #2;
        reset = 1'b0;
        r = cyc;
        for (int s = 0; s < 28; s++) begin
            on  = (s == 12) ? 4 : (s >= 13 && s <= 15) ? 1 : 16;
            sg  = (s < 8) ? SEG0 : (s < 20) ? seg12af[s % 4] : SEG8;
            dpv = (s >= 8 && s < 20 && (s % 4) == 1);
            push_slot(r + 2 + 16*s, s % 4, sg, dpv, on, 16);
        end
        pulse_load(r + 2 + 16*5 + 3, 16'h12AF, 4'b0010);
        wait_cyc(r + 2 + 16*11 + 5);  bright_i = 4'd3;
        wait_cyc(r + 2 + 16*12 + 8);  bright_i = 4'd0;
        wait_cyc(r + 2 + 16*15 + 8);  bright_i = 4'd15;
        pulse_load(r + 2 + 16*19 + 14, 16'h8888, 4'b0000);

        // run 2: reset asserted mid-slot must clear pins before the next edge
        wait_cyc(r + 2 + 16*28);
        reset = 1'b1;
        push_off(cyc);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        r = cyc;
        push_slot(r + 2,      0, SEG0, 1'b0, 16, 16);
        push_slot(r + 2 + 16, 1, SEG0, 1'b0, 16, 16);
        push_slot(r + 2 + 32, 2, SEG0, 1'b0, 16, 3);
        pulse_load(r + 10, 16'h3333, 4'b0000);
        wait_cyc(r + 37);
        reset = 1'b1;
        #1;
        push_off(cyc);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // run 3: cleared registers show zero, then 0050 with and without dp on digit 3
        r = cyc;
        for (int s = 0; s < 16; s++) begin
            sg  = (s >= 8 && (s % 4) == 1) ? SEG5 : SEG0;
            dpv = (s >= 12 && (s % 4) == 3);
            on  = 16;
`ifdef LEADING_ZERO_BLANK_EN
            if (s >= 8 && ((s % 4) == 2 || ((s % 4) == 3 && s < 12)))
                on = 0;
`endif
            push_slot(r + 2 + 16*s, s % 4, sg, dpv, on, 16);
        end
        pulse_load(r + 2 + 16*5 + 3, 16'h0050, 4'b0000);
        pulse_load(r + 2 + 16*9 + 3, 16'h0050, 4'b1000);
        wait_cyc(r + 2 + 16*16 + 2);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
